// File: rtl/dda_link_pkg.sv
// rtl/dda_link_pkg.sv - shared command codes, FSM state enums and default SYNC byte for the DDA link
// No ports. Imported by dda_link_ctrl and dda_link_tx.
package dda_link_pkg;

    localparam logic [7:0] CMD_WRITE      = 8'h57;  // 'W': address byte then data byte follow
    localparam logic [7:0] CMD_STREAM_ON  = 8'h53;  // 'S'
    localparam logic [7:0] CMD_STREAM_OFF = 8'h50;  // 'P'
    localparam logic [7:0] CMD_DDA_EN     = 8'h45;  // 'E'
    localparam logic [7:0] CMD_DDA_DIS    = 8'h44;  // 'D'

    localparam logic [7:0] SYNC_DEFAULT   = 8'h7E;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_ADDR,
        RX_DATA
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_ISSUE,
        TX_GAP
    } tx_state_t;

endpackage

// File: rtl/dda_link_tx.sv
// rtl/dda_link_tx.sv - telemetry frame serialiser: snapshot, byte index, UART handshake, optional checksum
// Ports: clk, rst (sync, active-high); stream_active, state_in[CHANNELS*W] in;
//        tx_busy in; tx_start / tx_byte[8] out (registered).
// Optional feature: LINK_CHECKSUM_EN appends the XOR of the payload bytes to each frame.
module dda_link_tx
    import dda_link_pkg::*;
#(
    parameter int         W        = 16,
    parameter int         CHANNELS = 3,
    parameter logic [7:0] SYNC     = SYNC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stream_active,
    input  logic [CHANNELS*W-1:0] state_in,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            tx_byte
);

    localparam int PW      = CHANNELS * W;
    localparam int PAYLOAD = PW / 8;
`ifdef LINK_CHECKSUM_EN
    localparam int FRAME_BYTES = PAYLOAD + 2;
`else
    localparam int FRAME_BYTES = PAYLOAD + 1;
`endif
    localparam int IW = $clog2(FRAME_BYTES + 1);

    tx_state_t         state_q, state_d;
    logic [PW-1:0]     snap_q, snap_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic [7:0]        cur_byte;
    logic              is_payload;
`ifdef LINK_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        idx_d      = idx_q;
        tx_start_d = 1'b0;
        tx_byte_d  = tx_byte_q;
`ifdef LINK_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        // idx_q counts bytes already issued; the snapshot is shifted left as
        // payload bytes go out so the next one is always in the top byte.
        is_payload = (idx_q != '0);
        cur_byte   = (idx_q == '0) ? SYNC : snap_q[PW-1 -: 8];
`ifdef LINK_CHECKSUM_EN
        if (idx_q == IW'(FRAME_BYTES - 1)) begin
            is_payload = 1'b0;
            cur_byte   = csum_q;
        end
`endif

        case (state_q)
            TX_IDLE: begin
                if (stream_active) begin
                    snap_d  = state_in;
                    idx_d   = '0;
`ifdef LINK_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                    state_d = TX_ISSUE;
                end
            end
            TX_ISSUE: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_byte_d  = cur_byte;
                    idx_d      = idx_q + IW'(1);
                    if (is_payload) begin
                        snap_d = snap_q << 8;
`ifdef LINK_CHECKSUM_EN
                        csum_d = csum_q ^ cur_byte;
`endif
                    end
                    state_d = TX_GAP;
                end
            end
            TX_GAP: begin
                if (idx_q == IW'(FRAME_BYTES)) begin
                    // Back-to-back frames: take the next snapshot here rather
                    // than spending a cycle in IDLE.
                    if (stream_active) begin
                        snap_d  = state_in;
                        idx_d   = '0;
`ifdef LINK_CHECKSUM_EN
                        csum_d  = 8'h00;
`endif
                        state_d = TX_ISSUE;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    state_d = TX_ISSUE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TX_IDLE;
            snap_q     <= '0;
            idx_q      <= '0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= 8'h00;
`ifdef LINK_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            idx_q      <= idx_d;
            tx_start_q <= tx_start_d;
            tx_byte_q  <= tx_byte_d;
`ifdef LINK_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign tx_start = tx_start_q;
    assign tx_byte  = tx_byte_q;

endmodule

// File: rtl/dda_link_ctrl.sv
// rtl/dda_link_ctrl.sv - DDA UART link: command decoder, parameter file and telemetry streamer
// Ports: clk, rst (sync, active-high); rx_valid, rx_byte[8] in; tx_busy in;
//        tx_start, tx_byte[8] out; state_in[CHANNELS*W] in; param_out[REG_BYTES*8] out;
//        dda_en, stream_active out.
// Optional feature: LINK_CHECKSUM_EN (handled in dda_link_tx) adds a payload XOR byte per frame.
module dda_link_ctrl
    import dda_link_pkg::*;
#(
    parameter int                     W         = 16,
    parameter int                     CHANNELS  = 3,
    parameter int                     REG_BYTES = 14,
    parameter logic [REG_BYTES*8-1:0] INIT      = '0,
    parameter logic [7:0]             SYNC      = SYNC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_byte,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [7:0]             tx_byte,
    input  logic [CHANNELS*W-1:0]  state_in,
    output logic [REG_BYTES*8-1:0] param_out,
    output logic                   dda_en,
    output logic                   stream_active
);

    rx_state_t              rx_state_q, rx_state_d;
    logic [7:0]             addr_q, addr_d;
    logic [REG_BYTES*8-1:0] param_q, param_d;
    logic                   dda_en_q, dda_en_d;
    logic                   stream_q, stream_d;

    always_comb begin
        rx_state_d = rx_state_q;
        addr_d     = addr_q;
        param_d    = param_q;
        dda_en_d   = dda_en_q;
        stream_d   = stream_q;

        if (rx_valid) begin
            case (rx_state_q)
                RX_IDLE: begin
                    case (rx_byte)
                        CMD_WRITE:      rx_state_d = RX_ADDR;
                        CMD_STREAM_ON:  stream_d   = 1'b1;
                        CMD_STREAM_OFF: stream_d   = 1'b0;
                        CMD_DDA_EN:     dda_en_d   = 1'b1;
                        CMD_DDA_DIS:    dda_en_d   = 1'b0;
                        default:        ;
                    endcase
                end
                RX_ADDR: begin
                    addr_d     = rx_byte;
                    rx_state_d = RX_DATA;
                end
                RX_DATA: begin
                    // Out-of-range addresses match no slot, so the byte is dropped.
                    for (int i = 0; i < REG_BYTES; i++) begin
                        if (addr_q == 8'(i)) begin
                            param_d[(REG_BYTES-1-i)*8 +: 8] = rx_byte;
                        end
                    end
                    rx_state_d = RX_IDLE;
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            addr_q     <= 8'h00;
            param_q    <= INIT;
            dda_en_q   <= 1'b1;
            stream_q   <= 1'b1;
        end else begin
            rx_state_q <= rx_state_d;
            addr_q     <= addr_d;
            param_q    <= param_d;
            dda_en_q   <= dda_en_d;
            stream_q   <= stream_d;
        end
    end

    assign param_out     = param_q;
    assign dda_en        = dda_en_q;
    assign stream_active = stream_q;

    dda_link_tx #(
        .W        (W),
        .CHANNELS (CHANNELS),
        .SYNC     (SYNC)
    ) u_tx (
        .clk           (clk),
        .rst           (rst),
        .stream_active (stream_q),
        .state_in      (state_in),
        .tx_busy       (tx_busy),
        .tx_start      (tx_start),
        .tx_byte       (tx_byte)
    );

endmodule
